// File: rtl/xdma_cfg_deframer.sv
// Receive-side cfg frame deframer: registers the first-frame header, then forwards continuation payloads.
// Optional protocol check enabled by defining XDMA_CFG_DEFRAMER_CHECK_EN.
module xdma_cfg_deframer #(
    parameter int unsigned AxiDataWidth    = 512,
    parameter int unsigned AddrWidth       = 48,
    parameter int unsigned DMAIdWidth      = 4,
    parameter int unsigned TotalFrameWidth = 4
) (
    input  logic                                                            clk_i,
    input  logic                                                            rst_i,
    input  logic [AxiDataWidth-1:0]                                         cfg_i,
    input  logic                                                            cfg_valid_i,
    output logic                                                            cfg_ready_o,
    output logic                                                            hdr_valid_o,
    input  logic                                                            hdr_ready_i,
    output logic                                                            hdr_dma_type_o,
    output logic [TotalFrameWidth-1:0]                                      hdr_frame_length_o,
    output logic [DMAIdWidth-1:0]                                           hdr_dma_id_o,
    output logic [AddrWidth-1:0]                                            hdr_reader_addr_o,
    output logic [AddrWidth-1:0]                                            hdr_writer_addr_o,
    output logic [AxiDataWidth-1-TotalFrameWidth-DMAIdWidth-2*AddrWidth-1:0] hdr_payload_o,
    output logic                                                            pld_valid_o,
    input  logic                                                            pld_ready_i,
    output logic [AxiDataWidth-1-TotalFrameWidth-1:0]                       pld_data_o,
    output logic                                                            pld_last_o,
    output logic                                                            err_o
);

    localparam int unsigned IdLsb  = 1 + TotalFrameWidth;
    localparam int unsigned RdLsb  = IdLsb + DMAIdWidth;
    localparam int unsigned WrLsb  = RdLsb + AddrWidth;
    localparam int unsigned HplLsb = WrLsb + AddrWidth;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY
    } state_e;

    state_e                     state_q, state_d;
    logic                       run_q;
    logic                       cfg_ready;
    logic                       accept;
    logic [TotalFrameWidth-1:0] rem_cnt_q;
    logic [TotalFrameWidth-1:0] frame_len_in;

    assign frame_len_in = cfg_i[TotalFrameWidth:1];
    assign cfg_ready_o  = cfg_ready;
    assign accept       = cfg_valid_i && cfg_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // run_q holds cfg_ready low during and right after reset; IDLE also waits for the last payload to drain.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = run_q && !pld_valid_o;
                if (cfg_valid_i && cfg_ready) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (hdr_ready_i) state_d = (rem_cnt_q != '0) ? ST_BODY : ST_IDLE;
            end
            ST_BODY: begin
                cfg_ready = !pld_valid_o || pld_ready_i;
                if (cfg_valid_i && cfg_ready && rem_cnt_q == TotalFrameWidth'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hdr_valid_o        <= 1'b0;
            hdr_dma_type_o     <= 1'b0;
            hdr_frame_length_o <= '0;
            hdr_dma_id_o       <= '0;
            hdr_reader_addr_o  <= '0;
            hdr_writer_addr_o  <= '0;
            hdr_payload_o      <= '0;
            rem_cnt_q          <= '0;
            pld_valid_o        <= 1'b0;
            pld_data_o         <= '0;
            pld_last_o         <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && accept) begin
                hdr_valid_o        <= 1'b1;
                hdr_dma_type_o     <= cfg_i[0];
                hdr_frame_length_o <= frame_len_in;
                hdr_dma_id_o       <= cfg_i[IdLsb +: DMAIdWidth];
                hdr_reader_addr_o  <= cfg_i[RdLsb +: AddrWidth];
                hdr_writer_addr_o  <= cfg_i[WrLsb +: AddrWidth];
                hdr_payload_o      <= cfg_i[AxiDataWidth-1:HplLsb];
                rem_cnt_q          <= (frame_len_in == '0) ? '0 : frame_len_in - TotalFrameWidth'(1);
            end else if (state_q == ST_HDR && hdr_ready_i) begin
                hdr_valid_o <= 1'b0;
            end

            // Accept and pop in the same cycle reloads the register, so valid stays high.
            if (state_q == ST_BODY && accept) begin
                pld_valid_o <= 1'b1;
                pld_data_o  <= cfg_i[AxiDataWidth-1:TotalFrameWidth+1];
                pld_last_o  <= (rem_cnt_q == TotalFrameWidth'(1));
                if (rem_cnt_q != '0) rem_cnt_q <= rem_cnt_q - TotalFrameWidth'(1);
            end else if (pld_valid_o && pld_ready_i) begin
                pld_valid_o <= 1'b0;
            end
        end
    end

`ifdef XDMA_CFG_DEFRAMER_CHECK_EN
    logic err_d;
    logic err_q;

    always_comb begin
        err_d = 1'b0;
        if (accept) begin
            if (state_q == ST_IDLE)
                err_d = (frame_len_in == '0);
            else if (state_q == ST_BODY)
                err_d = (cfg_i[0] != hdr_dma_type_o) || (frame_len_in != hdr_frame_length_o);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_xdma_cfg_deframer.sv
// Directed bench for xdma_cfg_deframer: header vector table plus multi-cycle corner sequences.
module tb_xdma_cfg_deframer;

`ifdef XDMA_CFG_DEFRAMER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [511:0] cfg_i;
    logic         cfg_valid_i;
    logic         cfg_ready_o;
    logic         hdr_valid_o;
    logic         hdr_ready_i;
    logic         hdr_dma_type_o;
    logic [3:0]   hdr_frame_length_o;
    logic [3:0]   hdr_dma_id_o;
    logic [47:0]  hdr_reader_addr_o;
    logic [47:0]  hdr_writer_addr_o;
    logic [406:0] hdr_payload_o;
    logic         pld_valid_o;
    logic         pld_ready_i;
    logic [506:0] pld_data_o;
    logic         pld_last_o;
    logic         err_o;

    int tests = 0;
    int fails = 0;

    xdma_cfg_deframer #(
        .AxiDataWidth   (512),
        .AddrWidth      (48),
        .DMAIdWidth     (4),
        .TotalFrameWidth(4)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cfg_i             (cfg_i),
        .cfg_valid_i       (cfg_valid_i),
        .cfg_ready_o       (cfg_ready_o),
        .hdr_valid_o       (hdr_valid_o),
        .hdr_ready_i       (hdr_ready_i),
        .hdr_dma_type_o    (hdr_dma_type_o),
        .hdr_frame_length_o(hdr_frame_length_o),
        .hdr_dma_id_o      (hdr_dma_id_o),
        .hdr_reader_addr_o (hdr_reader_addr_o),
        .hdr_writer_addr_o (hdr_writer_addr_o),
        .hdr_payload_o     (hdr_payload_o),
        .pld_valid_o       (pld_valid_o),
        .pld_ready_i       (pld_ready_i),
        .pld_data_o        (pld_data_o),
        .pld_last_o        (pld_last_o),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         dt;
        logic [3:0]   fl;
        logic [3:0]   id;
        logic [47:0]  ra;
        logic [47:0]  wa;
        logic [406:0] pl;
        logic         exp_err;
    } hvec_t;

    hvec_t vec [4];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [511:0] first_frame(input logic dt, input logic [3:0] fl, input logic [3:0] id,
                                                 input logic [47:0] ra, input logic [47:0] wa,
                                                 input logic [406:0] pl);
        return {pl, wa, ra, id, fl, dt};
    endfunction

    function automatic logic [511:0] cont_frame(input logic dt, input logic [3:0] fl, input logic [506:0] pl);
        return {pl, fl, dt};
    endfunction

    task automatic hdr_handshake();
        hdr_ready_i = 1'b1;
        tick();
        hdr_ready_i = 1'b0;
    endtask

    logic [506:0] pb [3];
    logic [506:0] pa1, pa2, pc;
    int           sent, got;
    bit           acc, pop;

    initial begin
        vec[0] = '{1'b1, 4'd1, 4'h3, 48'h1000, 48'h2000, 407'h1234_5678_9ABC, 1'b0};
        vec[1] = '{1'b0, 4'd1, 4'hF, 48'hFFFF_FFFF_FFFF, 48'h0, {407{1'b1}}, 1'b0};
        vec[2] = '{1'b1, 4'd0, 4'h8, 48'hABCD_0000_1111, 48'h8000_0000_0001, 407'h5A5A, CHK};
        vec[3] = '{1'b0, 4'd1, 4'h1, 48'h0000_5555_AAAA, 48'hAAAA_5555_0000, {1'b1, 406'h0}, 1'b0};

        rst_i = 1'b1; cfg_i = '0; cfg_valid_i = 1'b0; hdr_ready_i = 1'b0; pld_ready_i = 1'b0;
        #1;
        chk("rst_cfg_ready", 512'(cfg_ready_o), 512'(0));
        chk("rst_hdr_valid", 512'(hdr_valid_o), 512'(0));
        chk("rst_pld_valid", 512'(pld_valid_o), 512'(0));
        chk("rst_err", 512'(err_o), 512'(0));
        tick(); tick();
        rst_i = 1'b0;
        tick();
        chk("idle_cfg_ready", 512'(cfg_ready_o), 512'(1));

        // Header-only frames from the table
        for (int i = 0; i < 4; i++) begin
            cfg_i = first_frame(vec[i].dt, vec[i].fl, vec[i].id, vec[i].ra, vec[i].wa, vec[i].pl);
            cfg_valid_i = 1'b1;
            #1;
            chk($sformatf("v%0d_ready_in", i), 512'(cfg_ready_o), 512'(1));
            tick();
            cfg_valid_i = 1'b0;
            chk($sformatf("v%0d_hdr_valid", i), 512'(hdr_valid_o), 512'(1));
            chk($sformatf("v%0d_type", i), 512'(hdr_dma_type_o), 512'(vec[i].dt));
            chk($sformatf("v%0d_len", i), 512'(hdr_frame_length_o), 512'(vec[i].fl));
            chk($sformatf("v%0d_id", i), 512'(hdr_dma_id_o), 512'(vec[i].id));
            chk($sformatf("v%0d_rd", i), 512'(hdr_reader_addr_o), 512'(vec[i].ra));
            chk($sformatf("v%0d_wr", i), 512'(hdr_writer_addr_o), 512'(vec[i].wa));
            chk($sformatf("v%0d_hpl", i), 512'(hdr_payload_o), 512'(vec[i].pl));
            chk($sformatf("v%0d_err", i), 512'(err_o), 512'(vec[i].exp_err));
            chk($sformatf("v%0d_ready_hdr", i), 512'(cfg_ready_o), 512'(0));
            hdr_handshake();
            chk($sformatf("v%0d_hdr_drop", i), 512'(hdr_valid_o), 512'(0));
            chk($sformatf("v%0d_err_end", i), 512'(err_o), 512'(0));
            chk($sformatf("v%0d_no_pld", i), 512'(pld_valid_o), 512'(0));
            chk($sformatf("v%0d_ready_back", i), 512'(cfg_ready_o), 512'(1));
        end

        // frame_length=3 with header stalled for 5 cycles
        pa1 = 507'h1111_2222_3333; pa2 = {1'b1, 506'h77};
        cfg_i = first_frame(1'b0, 4'd3, 4'h5, 48'hCAFE_0000, 48'hBEEF_0000, 407'h9);
        cfg_valid_i = 1'b1;
        tick();
        cfg_i = cont_frame(1'b0, 4'd3, pa1);
        for (int k = 0; k < 5; k++) begin
            chk("s3_stall_ready", 512'(cfg_ready_o), 512'(0));
            chk("s3_stall_hvalid", 512'(hdr_valid_o), 512'(1));
            chk("s3_stall_rd", 512'(hdr_reader_addr_o), 512'(48'hCAFE_0000));
            tick();
        end
        hdr_handshake();
        chk("s3_hdr_drop", 512'(hdr_valid_o), 512'(0));
        chk("s3_no_early_pld", 512'(pld_valid_o), 512'(0));
        tick();
        chk("s3_p1_valid", 512'(pld_valid_o), 512'(1));
        chk("s3_p1_data", 512'(pld_data_o), 512'(pa1));
        chk("s3_p1_last", 512'(pld_last_o), 512'(0));
        cfg_i = cont_frame(1'b0, 4'd3, pa2);
        pld_ready_i = 1'b1;
        #1;
        chk("s3_ready_pop", 512'(cfg_ready_o), 512'(1));
        tick();
        cfg_valid_i = 1'b0;
        chk("s3_p2_valid", 512'(pld_valid_o), 512'(1));
        chk("s3_p2_data", 512'(pld_data_o), 512'(pa2));
        chk("s3_p2_last", 512'(pld_last_o), 512'(1));
        tick();
        chk("s3_drained", 512'(pld_valid_o), 512'(0));
        chk("s3_idle_ready", 512'(cfg_ready_o), 512'(1));
        pld_ready_i = 1'b0;

        // frame_length=4, continuous valid, pld_ready toggling
        for (int i = 0; i < 3; i++) pb[i] = {7'(i + 1), 500'h0} ^ 507'(64'hC0DE_0000_1234_0000 + 64'(i));
        cfg_i = first_frame(1'b1, 4'd4, 4'hC, 48'h1, 48'h2, 407'h0);
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        hdr_handshake();
        sent = 0; got = 0;
        cfg_i = cont_frame(1'b1, 4'd4, pb[0]);
        cfg_valid_i = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            pld_ready_i = (cyc % 2 == 0);
            #1;
            if (sent < 3 && pld_ready_i) chk("s4_throughput", 512'(cfg_ready_o), 512'(1));
            acc = cfg_valid_i && cfg_ready_o;
            pop = pld_valid_o && pld_ready_i;
            if (pop) begin
                chk($sformatf("s4_data%0d", got), 512'(pld_data_o), 512'(pb[got]));
                chk($sformatf("s4_last%0d", got), 512'(pld_last_o), 512'(got == 2));
                got++;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent < 3) cfg_i = cont_frame(1'b1, 4'd4, pb[sent]);
                else cfg_valid_i = 1'b0;
            end
        end
        chk("s4_count", 512'(got), 512'(3));
        chk("s4_drained", 512'(pld_valid_o), 512'(0));
        chk("s4_idle_ready", 512'(cfg_ready_o), 512'(1));
        pld_ready_i = 1'b0;

        // Continuation with flipped dma_type
        pc = 507'hFACE;
        cfg_i = first_frame(1'b0, 4'd2, 4'h7, 48'h10, 48'h20, 407'h0);
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        hdr_handshake();
        chk("ck_err_quiet", 512'(err_o), 512'(0));
        cfg_i = cont_frame(1'b1, 4'd2, pc);
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        chk("ck_err_pulse", 512'(err_o), 512'(CHK));
        chk("ck_pld_valid", 512'(pld_valid_o), 512'(1));
        chk("ck_pld_data", 512'(pld_data_o), 512'(pc));
        chk("ck_pld_last", 512'(pld_last_o), 512'(1));
        tick();
        chk("ck_err_single", 512'(err_o), 512'(0));
        pld_ready_i = 1'b1;
        tick();
        pld_ready_i = 1'b0;
        chk("ck_drained", 512'(pld_valid_o), 512'(0));

        // New first frame must wait behind a stalled last payload
        cfg_i = first_frame(1'b1, 4'd2, 4'h2, 48'h30, 48'h40, 407'h0);
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        hdr_handshake();
        cfg_i = cont_frame(1'b1, 4'd2, 507'h33);
        cfg_valid_i = 1'b1;
        tick();
        cfg_i = first_frame(1'b0, 4'd1, 4'hA, 48'h50, 48'h60, 407'h1);
        for (int k = 0; k < 3; k++) begin
            chk("st_ready_blocked", 512'(cfg_ready_o), 512'(0));
            chk("st_no_hdr", 512'(hdr_valid_o), 512'(0));
            chk("st_pld_held", 512'(pld_valid_o), 512'(1));
            tick();
        end
        pld_ready_i = 1'b1;
        #1;
        chk("st_ready_popcycle", 512'(cfg_ready_o), 512'(0));
        tick();
        chk("st_popped", 512'(pld_valid_o), 512'(0));
        chk("st_ready_after", 512'(cfg_ready_o), 512'(1));
        tick();
        cfg_valid_i = 1'b0; pld_ready_i = 1'b0;
        chk("st_new_hdr", 512'(hdr_valid_o), 512'(1));
        chk("st_new_id", 512'(hdr_dma_id_o), 512'(4'hA));
        hdr_handshake();
        chk("st_idle_ready", 512'(cfg_ready_o), 512'(1));

        // Reset in the middle of a 4-frame body
        cfg_i = first_frame(1'b1, 4'd4, 4'h6, 48'h70, 48'h80, 407'h2);
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        hdr_handshake();
        cfg_i = cont_frame(1'b1, 4'd4, 507'h44);
        cfg_valid_i = 1'b1;
        pld_ready_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        chk("rb_pld1", 512'(pld_valid_o), 512'(1));
        tick();
        cfg_i = cont_frame(1'b1, 4'd4, 507'h55);
        cfg_valid_i = 1'b1;
        rst_i = 1'b1;
        #1;
        chk("rb_cfg_ready", 512'(cfg_ready_o), 512'(0));
        chk("rb_hdr_valid", 512'(hdr_valid_o), 512'(0));
        chk("rb_pld_valid", 512'(pld_valid_o), 512'(0));
        chk("rb_pld_data", 512'(pld_data_o), 512'(0));
        chk("rb_pld_last", 512'(pld_last_o), 512'(0));
        chk("rb_id", 512'(hdr_dma_id_o), 512'(0));
        chk("rb_rd", 512'(hdr_reader_addr_o), 512'(0));
        rst_i = 1'b0;
        cfg_valid_i = 1'b0;
        tick();
        chk("rb_ready_back", 512'(cfg_ready_o), 512'(1));
        cfg_i = first_frame(1'b0, 4'd1, 4'h9, 48'h90, 48'hA0, 407'h3);
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        chk("rb_new_hdr", 512'(hdr_valid_o), 512'(1));
        chk("rb_new_id", 512'(hdr_dma_id_o), 512'(4'h9));
        chk("rb_new_len", 512'(hdr_frame_length_o), 512'(4'd1));
        chk("rb_new_type", 512'(hdr_dma_type_o), 512'(0));
        hdr_handshake();
        chk("rb_no_pld", 512'(pld_valid_o), 512'(0));
        chk("rb_idle_ready", 512'(cfg_ready_o), 512'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xdma_cfg_deframer.md
Name: xdma_cfg_deframer

Overview:
- Receive side of the inter-cluster cfg frame protocol.
- Consumes 512-bit beats from the FromRemoteCfg decoder output and parses the first frame into a registered header (dma_type, frame_length, dma_id, reader_addr, writer_addr, first payload).
- Forwards continuation frames as payload beats with a last marker, using frame_length as the total frame count.
- Sits between the from-remote address decoder and the xDMA cfg/descriptor logic.

Parameters:
- AxiDataWidth, 512, beat width.
- AddrWidth, 48, reader/writer address width.
- DMAIdWidth, 4, dma_id width.
- TotalFrameWidth, 4, frame_length field width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cfg_i  in  AxiDataWidth  incoming cfg frame beat
- cfg_valid_i  in  1  beat valid
- cfg_ready_o  out  1  beat accepted
- hdr_valid_o  out  1  header valid
- hdr_ready_i  in  1  header accepted downstream
- hdr_dma_type_o  out  1  0 = read, 1 = write
- hdr_frame_length_o  out  TotalFrameWidth  total frames, including the first
- hdr_dma_id_o  out  DMAIdWidth  dma id
- hdr_reader_addr_o  out  AddrWidth  reader address
- hdr_writer_addr_o  out  AddrWidth  writer address
- hdr_payload_o  out  AxiDataWidth-1-TotalFrameWidth-DMAIdWidth-2*AddrWidth (407)  first-frame remaining payload
- pld_valid_o  out  1  continuation payload valid
- pld_ready_i  in  1  payload accepted
- pld_data_o  out  AxiDataWidth-1-TotalFrameWidth (507)  continuation payload
- pld_last_o  out  1  final frame of this cfg
- err_o  out  1  one-cycle protocol error pulse

Behaviour:
- Frame layout, LSB first.
  - First frame: [0] dma_type, [4:1] frame_length, [8:5] dma_id, [56:9] reader_addr, [104:57] writer_addr, [511:105] payload.
  - Continuation frame: [0] dma_type, [4:1] frame_length, [511:5] payload.
- Reset: all outputs and registers are 0; state IDLE; cfg_ready_o=0. Reset mid-cfg discards all partial state; the next accepted beat is treated as a first frame.
- IDLE:
  - cfg_ready_o=1.
  - On handshake: register all header fields; load rem_cnt = frame_length-1; go to HDR.
  - frame_length==0: rem_cnt=0 and err_o pulses (gated by the optional check).
- HDR:
  - hdr_valid_o=1 from the cycle after acceptance (latency 1); cfg_ready_o=0.
  - Header outputs stay stable until hdr_valid_o && hdr_ready_i.
  - On handshake: go to BODY if rem_cnt!=0, else IDLE.
- BODY:
  - One-entry payload output register.
  - cfg_ready_o = !pld_valid_o || pld_ready_i. This is full throughput: one beat per cycle with no bubble.
  - Accepted beat: pld_data_o=cfg_i[511:5]; pld_valid_o=1 the next cycle; pld_last_o=(rem_cnt==1); rem_cnt decrements.
  - When the last beat is accepted, go to IDLE. IDLE keeps cfg_ready_o low while pld_valid_o is still set, so a new first frame cannot overtake an undrained last payload.
- Simultaneous output pop and input accept in BODY: the register reloads in the same cycle and pld_valid_o stays 1.
- Payload outputs hold stable while pld_valid_o && !pld_ready_i.
- rem_cnt is TotalFrameWidth bits and never wraps: the decrement happens only when it is non-zero.
- err_o is never asserted for more than one cycle per event. Frames are always forwarded; errors never drop beats or cause resync.

Optional Feature:
- Macro: XDMA_CFG_DEFRAMER_CHECK_EN.
- Defined: on each continuation beat accepted, err_o pulses the next cycle if cfg_i[0] != the latched hdr_dma_type or cfg_i[4:1] != the latched frame_length. err_o also pulses for frame_length==0.
- Undefined: err_o is tied 0 and the comparison logic is not built. Datapath behaviour is otherwise identical.

Test Plan:
- Single frame, dma_type=1, frame_length=1, id=4'h3, reader=48'h1000, writer=48'h2000 -> hdr_valid_o one cycle later with exact fields; no pld_valid_o; returns to IDLE with cfg_ready_o=1.
- frame_length=3, hdr_ready_i held 0 for 5 cycles -> cfg_ready_o=0 throughout; header stable; after the handshake, 2 payloads with pld_last_o set only on the 2nd.
- frame_length=4, cfg_valid_i continuously high, pld_ready_i toggling 1,0,1,0 -> no beat lost or duplicated; payload order preserved; back-to-back throughput whenever pld_ready_i=1.
- CHECK_EN: frame_length=2 header, continuation with dma_type flipped -> err_o single-cycle pulse; payload still delivered with pld_last_o=1. frame_length=0 -> err_o pulse; header only.
- Reset asserted mid-BODY of a 4-frame cfg after 1 payload -> all outputs 0 immediately; the next beat parsed as a new header.
- Last payload stalled (pld_ready_i=0) while a new first frame is presented -> cfg_ready_o=0 until the last payload pops; then the new header is accepted.
